// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, flag bit positions and flag-update helpers.
package cpu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned FLAG_W = 3;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_XOR    = 4'd2,
        OP_RED    = 4'd3,
        OP_SLL    = 4'd4,
        OP_SRA    = 4'd5,
        OP_ROR    = 4'd6,
        OP_PADDSB = 4'd7,
        OP_LW     = 4'd8,
        OP_SW     = 4'd9,
        OP_LLB    = 4'd10,
        OP_LHB    = 4'd11,
        OP_B      = 4'd12,
        OP_BR     = 4'd13,
        OP_PCS    = 4'd14,
        OP_HLT    = 4'd15
    } opcode_e;

    // Opcodes that write all of Z, V and N.
    function automatic logic sets_zvn(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Opcodes that write Z only; V and N keep their value.
    function automatic logic sets_z_only(input logic [OP_W-1:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural flag register with an independent write enable per bit.
module flag_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLAG_W-1:0] en,
    input  logic [FLAG_W-1:0] d,
    output logic [FLAG_W-1:0] q
);

    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] flags_q;

    // Bitwise select: enabled bits take new value, others hold.
    always_comb begin
        flags_d = (en & d) | (~en & flags_q);
    end

    // Flag storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign q = flags_q;

endmodule

// File: rtl/ex_result_flags.sv
// EX/MEM boundary register: captures ALU result/opcode, maintains Z/V/N flags
// and counts saturating PADDSB operations for debug.
module ex_result_flags
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovfl,
    input  logic              stall,
    input  logic              flush,
    input  logic              sat_clr,
    output logic [DATA_W-1:0] result_q,
    output logic [OP_W-1:0]   op_q,
    output logic              valid_q,
    output logic              Z,
    output logic              V,
    output logic              N,
    output logic [FLAG_W-1:0] flags_next,
    output logic [CNT_W-1:0]  sat_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              upd_c;
    logic              zvn_c;
    logic              zonly_c;
    logic [FLAG_W-1:0] flag_en_c;
    logic [FLAG_W-1:0] flag_d_c;
    logic [FLAG_W-1:0] flags_cur;

    logic [DATA_W-1:0] res_d,  res_q;
    logic [OP_W-1:0]   opc_d,  opc_q;
    logic              vld_d,  vld_q;
    logic [CNT_W-1:0]  cnt_d,  cnt_q;

    // Flag write enables/data and the bypass view of the post-edge flags.
    always_comb begin
        upd_c   = valid_in & ~stall & ~flush;
        zvn_c   = sets_zvn(opcode);
        zonly_c = sets_z_only(opcode);

        flag_en_c         = '0;
        flag_en_c[FLAG_Z] = upd_c & (zvn_c | zonly_c);
        flag_en_c[FLAG_V] = upd_c & zvn_c;
        flag_en_c[FLAG_N] = upd_c & zvn_c;

        flag_d_c         = '0;
        flag_d_c[FLAG_Z] = (alu_result == '0);
        flag_d_c[FLAG_V] = alu_ovfl;
        flag_d_c[FLAG_N] = alu_result[DATA_W-1];

        flags_next = (flag_en_c & flag_d_c) | (~flag_en_c & flags_cur);
    end

    flag_reg u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flag_en_c),
        .d     (flag_d_c),
        .q     (flags_cur)
    );

    assign Z = flags_cur[FLAG_Z];
    assign V = flags_cur[FLAG_V];
    assign N = flags_cur[FLAG_N];

    // Pipeline register next state: flush kills valid only, stall holds all.
    always_comb begin
        res_d = res_q;
        opc_d = opc_q;
        vld_d = vld_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (!stall) begin
            res_d = alu_result;
            opc_d = opcode;
            vld_d = valid_in;
        end
    end

    // Saturation counter next state: clear wins, increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (upd_c && (opcode == OP_PADDSB) && alu_ovfl && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // EX/MEM and counter storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            opc_q <= '0;
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            res_q <= res_d;
            opc_q <= opc_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign result_q = res_q;
    assign op_q     = opc_q;
    assign valid_q  = vld_q;
    assign sat_cnt  = cnt_q;

endmodule

// File: tb/tb_ex_result_flags.sv
// Scoreboard bench for ex_result_flags: driver pushes model expectations,
// monitors pop and compare against the DUT.
module tb_ex_result_flags;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [3:0]  opcode;
    logic [15:0] alu_result;
    logic        alu_ovfl;
    logic        stall;
    logic        flush;
    logic        sat_clr;
    logic [15:0] result_q;
    logic [3:0]  op_q;
    logic        valid_q;
    logic        Z;
    logic        V;
    logic        N;
    logic [2:0]  flags_next;
    logic [15:0] sat_cnt;

    ex_result_flags #(.DATA_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .opcode     (opcode),
        .alu_result (alu_result),
        .alu_ovfl   (alu_ovfl),
        .stall      (stall),
        .flush      (flush),
        .sat_clr    (sat_clr),
        .result_q   (result_q),
        .op_q       (op_q),
        .valid_q    (valid_q),
        .Z          (Z),
        .V          (V),
        .N          (N),
        .flags_next (flags_next),
        .sat_cnt    (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  op;
        logic        vld;
        logic        z;
        logic        v;
        logic        n;
        logic [15:0] cnt;
    } snap_t;

    snap_t      exp_q[$];
    logic [2:0] fn_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [15:0] m_res;
    logic [3:0]  m_op;
    logic        m_vld;
    logic        m_z, m_v, m_n;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_res = '0; m_op = '0; m_vld = 1'b0;
        m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
        m_cnt = 0;
    endtask

    // Drive one cycle of stimulus and record what the DUT should show.
    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic st, input logic fl, input logic sc);
        bit    upd;
        snap_t s;
        @(negedge clk);
        valid_in = v; opcode = op; alu_result = res; alu_ovfl = ov;
        stall = st; flush = fl; sat_clr = sc;

        upd = v && !st && !fl;
        if (upd) begin
            case (op)
                4'd0, 4'd1: begin
                    m_z = (res == 16'd0);
                    m_v = ov;
                    m_n = (res >= 16'h8000);
                end
                4'd2, 4'd4, 4'd5, 4'd6: m_z = (res == 16'd0);
                default: ;
            endcase
        end
        fn_q.push_back({m_z, m_v, m_n});

        if (fl) begin
            m_vld = 1'b0;
        end else if (!st) begin
            m_res = res; m_op = op; m_vld = v;
        end

        if (sc) m_cnt = 0;
        else if (upd && op == 4'd7 && ov && m_cnt < 65535) m_cnt = m_cnt + 1;

        s.res = m_res; s.op = m_op; s.vld = m_vld;
        s.z = m_z; s.v = m_v; s.n = m_n; s.cnt = 16'(m_cnt);
        exp_q.push_back(s);
    endtask

    task automatic chk_all(input string tag, input snap_t s);
        chk({tag, "_result"}, 32'(result_q), 32'(s.res));
        chk({tag, "_op"},     32'(op_q),     32'(s.op));
        chk({tag, "_valid"},  32'(valid_q),  32'(s.vld));
        chk({tag, "_zvn"},    32'({Z, V, N}), 32'({s.z, s.v, s.n}));
        chk({tag, "_satcnt"}, 32'(sat_cnt),  32'(s.cnt));
    endtask

    // Registered-output monitor, shortly after each rising edge.
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk_all("reg", s);
            end
        end
    end

    // Bypass monitor, mid low phase while inputs are stable.
    initial begin
        logic [2:0] f;
        forever begin
            @(negedge clk);
            #2;
            if (fn_q.size() > 0) begin
                f = fn_q.pop_front();
                chk("flags_next", 32'(flags_next), 32'(f));
            end
        end
    end

    initial begin
        snap_t z;
        logic [3:0] rop;
        logic [15:0] rres;
        rst_n = 1'b0;
        valid_in = 1'b0; opcode = '0; alu_result = '0; alu_ovfl = 1'b0;
        stall = 1'b0; flush = 1'b0; sat_clr = 1'b0;
        model_reset();
        z = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_all("por", z);
        #1;
        rst_n = 1'b1;

        // Directed flag and pipeline scenarios
        drive(1, 4'd0, 16'h0000, 0, 0, 0, 0);   // ADD 0 -> Z=1
        drive(1, 4'd1, 16'h8000, 1, 0, 0, 0);   // SUB -> Z=0 V=1 N=1
        drive(1, 4'd2, 16'h0000, 0, 0, 0, 0);   // XOR 0 -> 111
        drive(1, 4'd7, 16'h7787, 1, 0, 0, 0);   // PADDSB sat -> cnt 1
        drive(0, 4'd7, 16'h7787, 1, 0, 0, 0);   // bubble, no count
        drive(1, 4'd0, 16'h0000, 0, 1, 0, 0);   // stalled ADD
        drive(1, 4'd0, 16'h0000, 0, 1, 1, 0);   // stall+flush
        drive(1, 4'd3, 16'h0000, 1, 0, 0, 0);   // RED leaves flags
        drive(1, 4'd5, 16'h8001, 1, 0, 0, 0);   // SRA nonzero -> Z=0 only

        // Asynchronous reset between edges
        drive(1, 4'd0, 16'h1234, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", z);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1, 4'd1, 16'hFFFF, 0, 0, 0, 0);   // first edge after reset loads

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rop  = 4'($urandom_range(0, 15));
            rres = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            drive(($urandom_range(0, 9) < 8), rop, rres, 1'($urandom),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 99) < 5));
        end

        // Counter saturation and clear priority
        drive(0, 4'd0, 16'h0000, 0, 0, 0, 1);
        for (int i = 0; i < 65535; i++) drive(1, 4'd7, 16'h8000, 1, 0, 0, 0);
        drive(1, 4'd7, 16'h8000, 1, 0, 0, 0);   // stays at 0xFFFF
        drive(1, 4'd7, 16'h8000, 1, 1, 0, 0);   // stalled: no count, still max
        drive(1, 4'd7, 16'h8000, 1, 1, 0, 1);   // clear despite stall
        drive(1, 4'd7, 16'h8000, 1, 0, 0, 0);   // counts again -> 1
        drive(1, 4'd7, 16'h8000, 1, 0, 0, 1);   // clear beats increment -> 0
        drive(0, 4'd0, 16'h0000, 0, 0, 0, 0);

        for (int i = 0; i < 20 && (exp_q.size() > 0 || fn_q.size() > 0); i++) @(posedge clk);
        #5;
        n_tests++;
        if (exp_q.size() > 0 || fn_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d reg and %0d bypass entries left, expected 0",
                     exp_q.size(), fn_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
